// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the PC, issues one single-word request at a time to instruction memory,
// holds the returned word with its PC until the decoder takes it, and handles
// redirects from execute, including dropping responses that are no longer wanted.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] instr_pc_o,
  output logic        fetch_err_o
);

  // FETCH issues the request, WAIT expects its response, DROP swallows a
  // response that a redirect made stale, VALID holds a word for the decoder,
  // HALT is the dead end after a misaligned redirect.
  typedef enum logic [2:0] {
    ST_FETCH,
    ST_WAIT,
    ST_DROP,
    ST_VALID,
    ST_HALT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        fetch_err_q;
  logic        br_misaligned;

  // A redirect to a non-word-aligned target is fatal for the fetch stream.
  assign br_misaligned = br_taken_i && (br_target_i[1:0] != 2'b00);

  // Request strobe and outward-facing views of the held instruction.
  always_comb begin
    imem_req_o    = rst_ni && (state_q == ST_FETCH) && !br_taken_i;
    imem_addr_o   = imem_req_o ? pc_q : 32'h0000_0000;
    instr_valid_o = instr_valid_q;
    instruction_o = instr_valid_q ? instr_q : NOP_INSTR;
    instr_pc_o    = instr_pc_q;
    fetch_err_o   = fetch_err_q;
  end

  // Fetch sequencing: a redirect always wins over whatever else happens this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else if (br_misaligned && (state_q != ST_HALT)) begin
      fetch_err_q   <= 1'b1;
      instr_valid_q <= 1'b0;
      state_q       <= ST_HALT;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (br_taken_i) begin
            pc_q <= br_target_i;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (br_taken_i) begin
            pc_q    <= br_target_i;
            state_q <= imem_rvalid_i ? ST_FETCH : ST_DROP;
          end else if (imem_rvalid_i) begin
            instr_q       <= imem_rdata_i;
            instr_pc_q    <= pc_q;
            pc_q          <= pc_q + 32'd4;
            instr_valid_q <= 1'b1;
            state_q       <= ST_VALID;
          end
        end
        ST_DROP: begin
          if (br_taken_i) begin
            pc_q <= br_target_i;
          end
          if (imem_rvalid_i) begin
            state_q <= ST_FETCH;
          end
        end
        ST_VALID: begin
          if (br_taken_i) begin
            pc_q          <= br_target_i;
            instr_valid_q <= 1'b0;
            state_q       <= ST_FETCH;
          end else if (instr_ready_i) begin
            instr_valid_q <= 1'b0;
            state_q       <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          instr_valid_q <= 1'b0;
          state_q       <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// transaction-level model of the fetch stream and a simple memory responder.
module tb_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fetch_err;

  logic        w_rst_n;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_br;
  logic [31:0] w_tgt;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_err;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .br_taken_i(br_taken), .br_target_i(br_target),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instruction_o(instruction), .instr_pc_o(instr_pc),
    .fetch_err_o(fetch_err)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk_i(clk), .rst_ni(w_rst_n),
    .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .br_taken_i(w_br), .br_target_i(w_tgt),
    .instr_valid_o(w_valid), .instr_ready_i(w_ready),
    .instruction_o(w_instr), .instr_pc_o(w_pc),
    .fetch_err_o(w_err)
  );

  int total = 0;
  int bad   = 0;

  // memory responder: one outstanding request, answers after mem_wait idle cycles
  logic        mem_pending;
  int          mem_wait;
  logic        fixed_data;
  logic [31:0] fixed_word;

  // fetch-stream model: next address, whether a response is owed and whether
  // it is unwanted, the word offered to the decoder, and the halted condition
  logic [31:0] m_pc;
  logic [31:0] m_word;
  logic [31:0] m_hpc;
  logic        m_busy;
  logic        m_stale;
  logic        m_held;
  logic        m_halt;
  logic        m_err;

  logic [31:0] req_log[$];
  logic [31:0] acc_log[$];
  int          n_req;
  int          n_acc;
  int          halt_cycles;
  logic        rnd_br;
  logic        rnd_rdy;
  logic [31:0] rnd_tgt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc    = 32'h0000_0000;
    m_word  = NOP;
    m_hpc   = 32'h0000_0000;
    m_busy  = 1'b0;
    m_stale = 1'b0;
    m_held  = 1'b0;
    m_halt  = 1'b0;
    m_err   = 1'b0;
  endtask

  // Called at a falling edge; holds reset for one cycle and releases it at the next falling edge.
  // A response still owed by memory is delivered in the first cycle after release.
  task automatic doReset();
    rst_n       = 1'b0;
    br_taken    = 1'b0;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    checkOutput("rst_req", imem_req, 1'b0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_instr", instruction, NOP);
    checkOutput("rst_pc", instr_pc, 32'h0);
    checkOutput("rst_err", fetch_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    if (mem_pending) mem_wait = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance memory and model.
  task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic rdy, input int lat);
    logic        rv;
    logic        exp_req;
    logic        saw_req;
    rv          = mem_pending && (mem_wait == 0);
    imem_rvalid = rv;
    imem_rdata  = fixed_data ? fixed_word : $urandom();
    br_taken    = br;
    br_target   = tgt;
    instr_ready = rdy;
    #1;
    exp_req = !m_halt && !m_busy && !m_held && !br;
    checkOutput("req", imem_req, exp_req);
    checkOutput("addr", imem_addr, exp_req ? m_pc : 32'h0);
    checkOutput("valid", instr_valid, m_held);
    checkOutput("instr", instruction, m_held ? m_word : NOP);
    if (m_held) checkOutput("instr_pc", instr_pc, m_hpc);
    checkOutput("err", fetch_err, m_err);
    saw_req = imem_req;
    if (saw_req) req_log.push_back(imem_addr);
    if (instr_valid && rdy) acc_log.push_back(instr_pc);
    @(posedge clk);
    if (rv) mem_pending = 1'b0;
    else if (mem_pending && mem_wait > 0) mem_wait--;
    if (saw_req) begin
      mem_pending = 1'b1;
      mem_wait    = lat;
    end
    if (m_halt) begin
      m_halt = 1'b1;
    end else if (br && (tgt[1:0] != 2'b00)) begin
      m_err  = 1'b1;
      m_halt = 1'b1;
      m_held = 1'b0;
    end else if (br) begin
      m_pc   = tgt;
      m_held = 1'b0;
      if (m_busy && rv) begin
        m_busy  = 1'b0;
        m_stale = 1'b0;
      end else if (m_busy) begin
        m_stale = 1'b1;
      end
    end else if (exp_req) begin
      m_busy  = 1'b1;
      m_stale = 1'b0;
    end else if (m_busy && rv) begin
      if (!m_stale) begin
        m_held = 1'b1;
        m_word = imem_rdata;
        m_hpc  = m_pc;
        m_pc   = m_pc + 32'd4;
      end
      m_busy  = 1'b0;
      m_stale = 1'b0;
    end else if (m_held && rdy) begin
      m_held = 1'b0;
    end
    @(negedge clk);
  endtask

  // Guard against a stuck run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, then randomized traffic, then the wrap-around instance.
  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    br_taken = 1'b0; br_target = 32'h0; instr_ready = 1'b0;
    w_rst_n = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    w_br = 1'b0; w_tgt = 32'h0; w_ready = 1'b0;
    mem_pending = 1'b0; mem_wait = 0; halt_cycles = 0;
    fixed_data = 1'b1; fixed_word = 32'h0050_0093;
    modelReset();

    @(negedge clk);
    doReset();

    $display("[TB] back-to-back fetch with ready held high");
    repeat (9) applyStimulus(1'b0, 32'h0, 1'b1, 0);
    checkOutput("t1_req_count", req_log.size(), 3);
    checkOutput("t1_req0", req_log[0], 32'h0);
    checkOutput("t1_req1", req_log[1], 32'h4);
    checkOutput("t1_req2", req_log[2], 32'h8);
    checkOutput("t1_acc_count", acc_log.size(), 3);
    checkOutput("t1_acc0", acc_log[0], 32'h0);
    checkOutput("t1_acc1", acc_log[1], 32'h4);

    $display("[TB] decoder stall for five cycles");
    n_req = req_log.size();
    repeat (7) applyStimulus(1'b0, 32'h0, 1'b0, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    checkOutput("t2_req_count", req_log.size(), n_req + 2);
    checkOutput("t2_next_req", req_log[$], 32'h10);
    checkOutput("t2_acc_pc", acc_log[$], 32'hC);

    $display("[TB] redirect while waiting on slow memory");
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    n_acc = acc_log.size();
    applyStimulus(1'b0, 32'h0, 1'b1, 3);
    applyStimulus(1'b1, 32'h100, 1'b1, 0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 0);
    checkOutput("t3_req", req_log[$], 32'h100);
    checkOutput("t3_no_valid", acc_log.size(), n_acc);

    $display("[TB] redirect coinciding with response");
    applyStimulus(1'b1, 32'h200, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    checkOutput("t4_req", req_log[$], 32'h200);
    checkOutput("t4_no_valid", acc_log.size(), n_acc);
    applyStimulus(1'b0, 32'h0, 1'b0, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 0);

    $display("[TB] misaligned redirect halts fetch");
    n_req = req_log.size();
    applyStimulus(1'b1, 32'h102, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 0);
    end
    checkOutput("t5_err", fetch_err, 1'b1);
    checkOutput("t5_noreq", req_log.size(), n_req);
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    checkOutput("t5_refetch", req_log[$], 32'h0);

    $display("[TB] asynchronous reset while an instruction is held");
    applyStimulus(1'b0, 32'h0, 1'b0, 0);
    instr_ready = 1'b0; br_taken = 1'b0; imem_rvalid = 1'b0;
    #1;
    checkOutput("pre_async_valid", instr_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", instr_valid, 1'b0);
    checkOutput("async_instr", instruction, NOP);
    checkOutput("async_req", imem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    $display("[TB] reset with a response still in flight");
    fixed_data = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 3);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    doReset();
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      rnd_br  = ($urandom_range(0, 99) < 12);
      rnd_rdy = ($urandom_range(0, 9) < 7);
      rnd_tgt = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : 32'h0000_1000;
      rnd_tgt = rnd_tgt + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 39) == 0) rnd_tgt[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(rnd_br, rnd_tgt, rnd_rdy, $urandom_range(0, 3));
      if (m_halt) halt_cycles++;
      if (halt_cycles >= 12 || $urandom_range(0, 199) == 0) begin
        doReset();
        halt_cycles = 0;
      end
    end

    $display("[TB] reset PC at top of address space");
    w_rst_n = 1'b1; w_ready = 1'b1;
    #1;
    checkOutput("wrap_req0", w_req, 1'b1);
    checkOutput("wrap_addr0", w_addr, WRAP_PC);
    @(negedge clk);
    w_rvalid = 1'b1; w_rdata = 32'h1234_5678;
    #1;
    checkOutput("wrap_wait_req", w_req, 1'b0);
    @(negedge clk);
    w_rvalid = 1'b0;
    #1;
    checkOutput("wrap_valid", w_valid, 1'b1);
    checkOutput("wrap_instr", w_instr, 32'h1234_5678);
    checkOutput("wrap_pc", w_pc, WRAP_PC);
    @(negedge clk);
    #1;
    checkOutput("wrap_req1", w_req, 1'b1);
    checkOutput("wrap_addr1", w_addr, 32'h0000_0000);
    @(negedge clk);
    #1;
    w_rst_n = 1'b0;
    #1;
    checkOutput("wrap_rst_valid", w_valid, 1'b0);
    checkOutput("wrap_rst_instr", w_instr, NOP);
    checkOutput("wrap_rst_req", w_req, 1'b0);
    checkOutput("wrap_rst_err", w_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
